// File: rtl/pipeline_hazard_ctrl.sv
// Purpose: sequencing/hazard controller for the 20-bit five-stage pipeline (boot freeze, load-use, MEM branches, memory waits).
// Latency: enables/flushes are a same-cycle combinational decode of (state, inputs); state and counters update on posedge.
// Backpressure: data-memory not-ready freezes PC..EX/MEM and bubbles MEM/WB; a wait of MEM_TIMEOUT cycles halts the core.
//
// Ports:
//   clock, reset (async, active-low)        - clock and reset
//   instr_id / instr_ex / instr_mem         - instruction words at IF/ID, ID/EX, EX/MEM outputs
//   branch_taken, mem_ready                 - branch condition for instr_mem, data-memory completion
//   pc_en, pc_sel_branch                    - PC update enable / load branch target
//   if_id_en, id_ex_en, ex_mem_en           - pipeline register enables
//   *_flush                                 - load a NOP into the corresponding register
//   state (0 BOOT,1 RUN,2 MEM_WAIT,3 HALT), mem_error (sticky), stall_cycles (perf counter)
//
// Optional feature macro: HAZARD_PERF_CNT_EN - when defined, stall_cycles counts cycles in RUN or
// MEM_WAIT with pc_en=0 (saturating at 16'hFFFF); when undefined it is tied to 0.

module pipeline_hazard_ctrl #(
  parameter int unsigned DATA_W      = 20,
  parameter logic [3:0]  OP_LOAD     = 4'h4,
  parameter logic [3:0]  OP_STORE    = 4'h5,
  parameter logic [3:0]  OP_BEQ      = 4'h6,
  parameter logic [3:0]  OP_JMP      = 4'h7,
  parameter int unsigned BOOT_CYCLES = 2,
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] instr_id,
  input  logic [DATA_W-1:0] instr_ex,
  input  logic [DATA_W-1:0] instr_mem,
  input  logic              branch_taken,
  input  logic              mem_ready,
  output logic              pc_en,
  output logic              pc_sel_branch,
  output logic              if_id_en,
  output logic              id_ex_en,
  output logic              ex_mem_en,
  output logic              if_id_flush,
  output logic              id_ex_flush,
  output logic              ex_mem_flush,
  output logic              mem_wb_flush,
  output logic [1:0]        state,
  output logic              mem_error,
  output logic [15:0]       stall_cycles
);

  typedef enum logic [1:0] {
    ST_BOOT     = 2'd0,
    ST_RUN      = 2'd1,
    ST_MEM_WAIT = 2'd2,
    ST_HALT     = 2'd3
  } state_e;

  // Last boot-count value before moving to RUN, and the wait count at which we give up.
  localparam logic [3:0] BOOT_LAST  = 4'(BOOT_CYCLES - 1);
  localparam logic [7:0] WAIT_LIMIT = 8'(MEM_TIMEOUT);

  state_e     state_q, state_d;
  logic [3:0] boot_cnt_q, boot_cnt_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       mem_error_q, mem_error_d;

  // Instruction fields (fixed positions, independent of DATA_W).
  logic [3:0] op_mem, op_ex, rd_ex, rs1_id, rs2_id;
  assign op_mem = instr_mem[19:16];
  assign op_ex  = instr_ex[19:16];
  assign rd_ex  = instr_ex[15:12];
  assign rs1_id = instr_id[11:8];
  assign rs2_id = instr_id[7:4];

  // Bits of the instruction words this block has no use for.
  logic unused_fields;
  assign unused_fields = ^{instr_id[19:12], instr_id[3:0], instr_ex[11:0], instr_mem[15:0]};

  logic mem_access, mem_stall_req, branch_req, load_use_req;
  assign mem_access    = (op_mem == OP_LOAD) || (op_mem == OP_STORE);
  assign mem_stall_req = mem_access && !mem_ready;
  assign branch_req    = (op_mem == OP_JMP) || ((op_mem == OP_BEQ) && branch_taken);
  // r0 is hardwired, so a load targeting it never needs a bubble; stores have no rd to forward.
  assign load_use_req  = (op_ex == OP_LOAD) && (rd_ex != 4'd0) &&
                         ((rd_ex == rs1_id) || (rd_ex == rs2_id));

  always_comb begin
    pc_en         = 1'b0;
    pc_sel_branch = 1'b0;
    if_id_en      = 1'b0;
    id_ex_en      = 1'b0;
    ex_mem_en     = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    ex_mem_flush  = 1'b0;
    mem_wb_flush  = 1'b0;
    state_d       = state_q;
    boot_cnt_d    = boot_cnt_q;
    wait_cnt_d    = wait_cnt_q;
    mem_error_d   = mem_error_q;

    case (state_q)
      ST_BOOT: begin
        // Everything frozen and filled with NOPs until the boot count expires.
        if_id_flush  = 1'b1;
        id_ex_flush  = 1'b1;
        ex_mem_flush = 1'b1;
        mem_wb_flush = 1'b1;
        if (boot_cnt_q == BOOT_LAST) begin
          state_d = ST_RUN;
        end else begin
          boot_cnt_d = boot_cnt_q + 4'd1;
        end
      end

      ST_RUN: begin
        if (mem_stall_req) begin
          // Freeze everything up to EX/MEM; MEM/WB takes a bubble while memory is busy.
          mem_wb_flush = 1'b1;
          state_d      = ST_MEM_WAIT;
          wait_cnt_d   = 8'd1;
        end else if (branch_req) begin
          // Redirect fetch and squash the three younger instructions; a pending
          // load-use on a squashed instruction is irrelevant.
          pc_en         = 1'b1;
          pc_sel_branch = 1'b1;
          if_id_en      = 1'b1;
          id_ex_en      = 1'b1;
          ex_mem_en     = 1'b1;
          if_id_flush   = 1'b1;
          id_ex_flush   = 1'b1;
          ex_mem_flush  = 1'b1;
        end else if (load_use_req) begin
          // Hold PC and IF/ID, let the load advance, and push one bubble into ID/EX.
          id_ex_en    = 1'b1;
          id_ex_flush = 1'b1;
          ex_mem_en   = 1'b1;
        end else begin
          pc_en     = 1'b1;
          if_id_en  = 1'b1;
          id_ex_en  = 1'b1;
          ex_mem_en = 1'b1;
        end
      end

      ST_MEM_WAIT: begin
        if (mem_ready) begin
          // Access completes this cycle: release the whole pipeline at once.
          pc_en     = 1'b1;
          if_id_en  = 1'b1;
          id_ex_en  = 1'b1;
          ex_mem_en = 1'b1;
          state_d   = ST_RUN;
        end else begin
          mem_wb_flush = 1'b1;
          if (wait_cnt_q == WAIT_LIMIT) begin
            state_d     = ST_HALT;
            mem_error_d = 1'b1;
          end else begin
            wait_cnt_d = wait_cnt_q + 8'd1;
          end
        end
      end

      ST_HALT: begin
        // Frozen with no flushes so the faulting state stays observable; only reset exits.
      end

      default: begin
        state_d = ST_HALT;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_BOOT;
      boot_cnt_q  <= 4'd0;
      wait_cnt_q  <= 8'd0;
      mem_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      boot_cnt_q  <= boot_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      mem_error_q <= mem_error_d;
    end
  end

  assign state     = state_q;
  assign mem_error = mem_error_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (((state_q == ST_RUN) || (state_q == ST_MEM_WAIT)) && !pc_en &&
        (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= 16'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cycles = stall_cnt_q;
`else
  assign stall_cycles = 16'd0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Purpose: self-checking bench for pipeline_hazard_ctrl against a cycle-level reference model.
// Latency: control outputs checked mid-cycle against the model; model state advances at each posedge.
// Backpressure: memory waits and timeouts are driven directly via mem_ready.

module tb_pipeline_hazard_ctrl;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_LOAD  = 4'h4;
  localparam logic [3:0] OP_STORE = 4'h5;
  localparam logic [3:0] OP_BEQ   = 4'h6;
  localparam logic [3:0] OP_JMP   = 4'h7;
  localparam int BOOT_CYCLES = 2;
  localparam int MEM_TIMEOUT = 16;
`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // Control vector bit order: pc_en, pc_sel_branch, if_id_en, id_ex_en, ex_mem_en,
  // if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush.
  localparam logic [8:0] V_BOOT    = 9'b0_0_000_1111;
  localparam logic [8:0] V_RUN     = 9'b1_0_111_0000;
  localparam logic [8:0] V_HALT    = 9'b0_0_000_0000;
  localparam logic [8:0] V_MSTALL  = 9'b0_0_000_0001;
  localparam logic [8:0] C_MSTALL  = 9'b1_0_111_0001;
  localparam logic [8:0] V_BRANCH  = 9'b1_1_000_1110;
  localparam logic [8:0] C_BRANCH  = 9'b1_1_000_1110;
  localparam logic [8:0] V_LDUSE   = 9'b0_0_001_0100;
  localparam logic [8:0] C_LDUSE   = 9'b1_1_101_0100;

  logic        clock = 1'b0;
  logic        reset;
  logic [19:0] instr_id, instr_ex, instr_mem;
  logic        branch_taken, mem_ready;
  logic        pc_en, pc_sel_branch, if_id_en, id_ex_en, ex_mem_en;
  logic        if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
  logic [1:0]  state;
  logic        mem_error;
  logic [15:0] stall_cycles;

  int tests = 0;
  int fails = 0;

  // Reference model: mode 0 BOOT, 1 RUN, 2 MEM_WAIT, 3 HALT; counts kept as plain integers.
  int m_mode, m_boot_seen, m_wait_len, m_err, m_stalls;
  logic [8:0] exp_v, care_v;
  bit         exp_stall;  // pc_en expected low this cycle in a counted mode

  always #5 clock = ~clock;

  pipeline_hazard_ctrl dut (
    .clock         (clock),
    .reset         (reset),
    .instr_id      (instr_id),
    .instr_ex      (instr_ex),
    .instr_mem     (instr_mem),
    .branch_taken  (branch_taken),
    .mem_ready     (mem_ready),
    .pc_en         (pc_en),
    .pc_sel_branch (pc_sel_branch),
    .if_id_en      (if_id_en),
    .id_ex_en      (id_ex_en),
    .ex_mem_en     (ex_mem_en),
    .if_id_flush   (if_id_flush),
    .id_ex_flush   (id_ex_flush),
    .ex_mem_flush  (ex_mem_flush),
    .mem_wb_flush  (mem_wb_flush),
    .state         (state),
    .mem_error     (mem_error),
    .stall_cycles  (stall_cycles)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  function automatic logic [19:0] mk(input logic [3:0] op, input logic [3:0] rd,
                                     input logic [3:0] rs1, input logic [3:0] rs2);
    return {op, rd, rs1, rs2, 4'h0};
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_boot_seen = 0; m_wait_len = 0; m_err = 0; m_stalls = 0;
  endtask

  // Expected controls for the current model mode and present inputs.
  task automatic model_comb();
    bit mem_op, taken, hazard;
    mem_op = (instr_mem[19:16] == OP_LOAD) || (instr_mem[19:16] == OP_STORE);
    taken  = (instr_mem[19:16] == OP_JMP) || (instr_mem[19:16] == OP_BEQ && branch_taken);
    hazard = (instr_ex[19:16] == OP_LOAD) && (instr_ex[15:12] != 0) &&
             (instr_ex[15:12] == instr_id[11:8] || instr_ex[15:12] == instr_id[7:4]);
    care_v = '1;
    exp_stall = 1'b0;
    case (m_mode)
      0: exp_v = V_BOOT;
      1: begin
        if (mem_op && !mem_ready) begin
          exp_v = V_MSTALL; care_v = C_MSTALL; exp_stall = 1'b1;
        end else if (taken) begin
          exp_v = V_BRANCH; care_v = C_BRANCH;
        end else if (hazard) begin
          exp_v = V_LDUSE; care_v = C_LDUSE; exp_stall = 1'b1;
        end else begin
          exp_v = V_RUN;
        end
      end
      2: begin
        if (mem_ready) exp_v = V_RUN;
        else begin exp_v = V_MSTALL; care_v = C_MSTALL; exp_stall = 1'b1; end
      end
      default: exp_v = V_HALT;
    endcase
  endtask

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_clock();
    model_comb();
    if (!reset) begin
      model_reset();
      return;
    end
    if (exp_stall && m_stalls < 65535) m_stalls++;
    case (m_mode)
      0: begin
        m_boot_seen++;
        if (m_boot_seen == BOOT_CYCLES) m_mode = 1;
      end
      1: if (exp_v == V_MSTALL) begin m_mode = 2; m_wait_len = 1; end
      2: begin
        if (mem_ready) m_mode = 1;
        else if (m_wait_len == MEM_TIMEOUT) begin m_mode = 3; m_err = 1; end
        else m_wait_len++;
      end
      default: ;
    endcase
  endtask

  task automatic check_all(input string tag);
    logic [8:0] obs;
    model_comb();
    obs = {pc_en, pc_sel_branch, if_id_en, id_ex_en, ex_mem_en,
           if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush};
    check({tag, "/ctl"}, {7'd0, obs & care_v}, {7'd0, exp_v & care_v});
    check({tag, "/state"}, {14'd0, state}, 16'(m_mode));
    check({tag, "/err"}, {15'd0, mem_error}, 16'(m_err));
    check({tag, "/perf"}, stall_cycles, PERF ? 16'(m_stalls) : 16'd0);
  endtask

  // Called just after a posedge with inputs already set: check mid-cycle, then clock the model.
  task automatic step(input string tag);
    #2;
    check_all(tag);
    @(posedge clock);
    model_clock();
    #1;
  endtask

  // Reset asserted between edges; outputs must reflect BOOT immediately.
  task automatic do_reset(input int cycles, input string tag);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    check_all(tag);
    repeat (cycles) step({tag, "_hold"});
    reset = 1'b1;
  endtask

  task automatic set_in(input logic [19:0] id, input logic [19:0] ex, input logic [19:0] mem,
                        input logic bt, input logic rdy);
    instr_id = id; instr_ex = ex; instr_mem = mem; branch_taken = bt; mem_ready = rdy;
  endtask

  initial begin
    logic [15:0] perf_before;
    reset = 1'b0;
    set_in('0, '0, '0, 1'b0, 1'b1);
    model_reset();
    #1;
    check_all("rst");
    repeat (3) step("rst_hold");
    reset = 1'b1;

    // Boot: two frozen cycles, then RUN with everything enabled.
    step("boot0");
    step("boot1");
    step("run0");
    check("run0_state_direct", {14'd0, state}, 16'd1);

    // Load-use on rs2, then the bubble clears; rd=0 never stalls; stores never stall.
    set_in(mk(4'h1, 4'd1, 4'd0, 4'd3), mk(OP_LOAD, 4'd3, 4'd0, 4'd0), '0, 1'b0, 1'b1);
    step("lduse_rs2");
    set_in(mk(4'h1, 4'd1, 4'd0, 4'd3), '0, '0, 1'b0, 1'b1);
    step("lduse_after");
    set_in(mk(4'h1, 4'd1, 4'd0, 4'd0), mk(OP_LOAD, 4'd0, 4'd0, 4'd0), '0, 1'b0, 1'b1);
    step("lduse_r0");
    set_in(mk(4'h1, 4'd1, 4'd5, 4'd0), mk(OP_LOAD, 4'd5, 4'd0, 4'd0), '0, 1'b0, 1'b1);
    step("lduse_rs1");
    set_in(mk(4'h1, 4'd1, 4'd5, 4'd0), mk(OP_STORE, 4'd5, 4'd0, 4'd0), '0, 1'b0, 1'b1);
    step("store_nohaz");

    // Taken BEQ overrides a simultaneous load-use; untaken BEQ lets the hazard through; JMP ignores branch_taken.
    set_in(mk(4'h1, 4'd1, 4'd3, 4'd0), mk(OP_LOAD, 4'd3, 4'd0, 4'd0), mk(OP_BEQ, 0, 1, 2), 1'b1, 1'b1);
    step("beq_taken");
    set_in(mk(4'h1, 4'd1, 4'd3, 4'd0), mk(OP_LOAD, 4'd3, 4'd0, 4'd0), mk(OP_BEQ, 0, 1, 2), 1'b0, 1'b1);
    step("beq_untaken");
    set_in('0, '0, mk(OP_JMP, 0, 0, 0), 1'b0, 1'b1);
    step("jmp");

    // Load waits three cycles on memory, then releases.
    perf_before = stall_cycles;
    set_in('0, '0, mk(OP_LOAD, 4'd2, 4'd1, 4'd0), 1'b1, 1'b0);
    repeat (3) step("mwait");
    check("mwait_state", {14'd0, state}, 16'd2);
    mem_ready = 1'b1;
    step("mwait_release");
    check("mwait_back_run", {14'd0, state}, 16'd1);
    check("mwait_perf3", stall_cycles - perf_before, PERF ? 16'd3 : 16'd0);

    // Async reset in the middle of a memory wait.
    set_in('0, '0, mk(OP_STORE, 4'd0, 4'd1, 4'd2), 1'b0, 1'b0);
    step("wait_a");
    step("wait_b");
    do_reset(2, "rst_midwait");
    set_in('0, '0, '0, 1'b0, 1'b1);
    repeat (3) step("reboot");

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      if (i % 100 == 99) do_reset(1, "rnd_rst");
      set_in(mk(4'($urandom_range(0, 7)), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
                4'($urandom_range(0, 3))),
             mk(4'($urandom_range(0, 7)), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
                4'($urandom_range(0, 3))),
             mk(4'($urandom_range(0, 7)), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
                4'($urandom_range(0, 3))),
             1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
      step("rnd");
    end

    // Store never completes: timeout into HALT, frozen until reset.
    do_reset(1, "pre_timeout");
    set_in('0, '0, '0, 1'b0, 1'b1);
    repeat (3) step("boot_t");
    set_in('0, '0, mk(OP_STORE, 4'd0, 4'd1, 4'd2), 1'b1, 1'b0);
    repeat (MEM_TIMEOUT + 1) step("timeout");
    check("halt_state", {14'd0, state}, 16'd3);
    check("halt_err", {15'd0, mem_error}, 16'd1);
    mem_ready = 1'b1;
    set_in(mk(4'h1, 0, 3, 0), mk(OP_LOAD, 3, 0, 0), mk(OP_JMP, 0, 0, 0), 1'b1, 1'b1);
    repeat (3) step("halt_frozen");
    do_reset(1, "rst_halt");
    check("rst_halt_err", {15'd0, mem_error}, 16'd0);
    check("rst_halt_state", {14'd0, state}, 16'd0);
    set_in('0, '0, '0, 1'b0, 1'b1);
    repeat (3) step("final");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
